// File: rtl/citrus_irq_pkg.sv
// ============================================================
// Package : citrus_irq_pkg
// Shared mode constants and index-width helper for the IRQ encoder.
// Rev     : 1.0
// ============================================================
`default_nettype none

package citrus_irq_pkg;

    localparam bit MODE_FIXED = 1'b0;
    localparam bit MODE_RR    = 1'b1;

    function automatic int clog2_w(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/prio_pick.sv
// ============================================================
// Module : prio_pick
// Combinational highest-set-index finder with any-set flag.
// Rev    : 1.0
// ============================================================
`default_nettype none

module prio_pick #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] i_vec,
    output logic [W-1:0] o_idx,
    output logic         o_any
);

    always_comb begin
        o_idx = '0;
        o_any = |i_vec;
        for (int i = 0; i < N; i++) begin
            if (i_vec[i]) begin
                o_idx = W'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/prio_irq_encoder.sv
// ============================================================
// Module : prio_irq_encoder
// Registered N-line interrupt priority encoder, valid/ack grant, 74148-style cascade.
// Rev    : 1.0
// ============================================================
`default_nettype none

module prio_irq_encoder
    import citrus_irq_pkg::*;
#(
    parameter  int N    = 8,
    parameter  int EDGE = 0,
    localparam int W    = clog2_w(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_enable,
    input  logic [N-1:0] in_req,
    input  logic [N-1:0] in_mask,
    input  logic         in_mode,
    input  logic         in_ack,
    output logic         out_valid,
    output logic [W-1:0] out_index,
    output logic         out_gs,
    output logic         out_enable
);

    logic [N-1:0] r_pending;
    logic [N-1:0] r_req_d;
    logic [W-1:0] r_ptr;
    logic         r_valid;
    logic [W-1:0] r_index;

    logic [N-1:0] w_raw;
    logic [N-1:0] w_cap;
    logic [N-1:0] w_clr;
    logic [N-1:0] w_cand;
    logic [N-1:0] w_rot;
    logic [W-1:0] w_ptr_eff;
    logic [W-1:0] w_rot_idx;
    logic [W:0]   w_sum;
    logic [W-1:0] w_pick;
    logic         w_any;
    logic         w_load;
    logic         w_unmasked_any;

    generate
        if (EDGE != 0) begin : g_edge
            assign w_raw = in_req & ~r_req_d;
        end else begin : g_level
            assign w_raw = in_req;
        end
    endgenerate

    assign w_cap = in_enable ? w_raw : '0;

    always_comb begin
        w_clr = '0;
        if (r_valid && in_ack) begin
            w_clr[r_index] = 1'b1;
        end
    end

    assign w_cand    = r_pending & ~in_mask & ~w_clr;
    assign w_ptr_eff = (in_mode == MODE_RR) ? r_ptr : '0;

    // Rotate so line ptr-1 lands on the top bit; a plain highest-index pick then yields RR order.
    always_comb begin
        w_rot = '0;
        for (int j = 0; j < N; j++) begin
            int s;
            s = j + int'(w_ptr_eff);
            if (s >= N) begin
                s = s - N;
            end
            w_rot[j] = w_cand[s];
        end
    end

    prio_pick #(
        .N (N),
        .W (W)
    ) u_pick (
        .i_vec (w_rot),
        .o_idx (w_rot_idx),
        .o_any (w_any)
    );

    assign w_sum  = {1'b0, w_rot_idx} + {1'b0, w_ptr_eff};
    assign w_pick = (w_sum >= (W+1)'(N)) ? W'(w_sum - (W+1)'(N)) : W'(w_sum);
    assign w_load = in_enable && (!r_valid || in_ack) && w_any;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
            r_req_d   <= '0;
            r_ptr     <= '0;
            r_valid   <= 1'b0;
            r_index   <= '0;
        end else begin
            r_req_d   <= in_req;
            r_pending <= (r_pending & ~w_clr) | w_cap;
            if (w_load) begin
                r_valid <= 1'b1;
                r_index <= w_pick;
                r_ptr   <= w_pick;
            end else if (in_ack) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign w_unmasked_any = |(r_pending & ~in_mask);
    assign out_valid      = r_valid;
    assign out_index      = r_index;
    assign out_gs         = in_enable & w_unmasked_any;
    assign out_enable     = in_enable & ~w_unmasked_any;

endmodule

`default_nettype wire
